inst_buffer: RTL and testbench
==============================

# inst_buffer

Instruction buffer between the fetch stage and the decoder. Each cycle it accepts up to four fetched instruction slots, packaged as `DECODE_REQUIRE[3:0]`, and stores them in a circular FIFO. It presents up to four oldest entries to decode and retires however many entries decode reports as consumed. It decouples fetch bandwidth from decode stalls and is cleared on a pipeline flush (branch mispredict or exception redirect).

## Interface
- `DEPTH`, default 16: number of entries. Must be a power of two and ≥ 8.
- `CNT_W`, default `$clog2(DEPTH)+1`: width of the occupancy counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous clear of all entries.
- `fetch_in` in `DECODE_REQUIRE[3:0]`: fetched slots; `.is_valid` marks real entries; index 0 is the oldest.
- `fetch_ready` out 1: buffer can take a full 4-slot group this cycle.
- `decode_out` out `DECODE_REQUIRE[3:0]`: oldest four entries; index 0 is the head.
- `decode_pop` in 3: number of entries decode consumed this cycle (0–4).
- `count` out `CNT_W`: current occupancy (registered).

## Operation
- **Storage.** `DEPTH` entries hold `pc`, `inst`, `predict_pc_addr` and `predict_brunch_taken`. State is `head` and `tail` pointers (`$clog2(DEPTH)` bits, wrapping modulo `DEPTH`) plus `count`.
- **Ready.**
  - `fetch_ready = (DEPTH - count) >= 4`, computed from the registered `count`.
  - Pops in the same cycle do not raise it; this is deliberately conservative.
- **Push.** When `fetch_ready && !flush`:
  - Every `fetch_in[i]` with `is_valid=1` is written in ascending `i` order, compacted, at `tail`, `tail+1`, …
  - `push_n` = number of valid slots (0–4).
  - `tail += push_n`.
  - Invalid slots are skipped even when they sit between valid ones.
- **Ignored push.** If `fetch_ready=0`, `fetch_in` is ignored. Fetch must hold its group until ready.
- **Output.**
  - `decode_out[i]` shows the entry at `head+i` (mod `DEPTH`), with `is_valid = (i < count)`.
  - Slots with `is_valid=0` drive all fields to 0.
  - Outputs are a combinational read of registered state only; there is no path from `fetch_in` to `decode_out`.
- **Pop.**
  - `pop_n = min(decode_pop, count)`; values of 5–7 are clipped the same way.
  - `head += pop_n`.
- **Simultaneous push and pop.** Both apply: `count <= count + push_n - pop_n`.
- **Flush.** Highest priority after reset:
  - `head`, `tail` and `count` are cleared to 0.
  - Push and pop in the same cycle are discarded.
  - Entry data need not be cleared.
- **Reset** (async, `rst_n=0`): `head=tail=count=0`.
  - Reset outputs: `fetch_ready=1`, `count=0`, `decode_out` all zero with `is_valid=0`.
  - Reset asserted mid-operation drops all contents immediately, without waiting for a clock edge.
- **Wrap-around.** Pointer arithmetic wraps modulo `DEPTH`. Full is distinguished from empty by `count`, never by pointer equality.

## Timing
- **Push latency.** An entry pushed at edge N is visible on `decode_out` after edge N, i.e. one cycle after it is presented.
- **Pop effect.** A pop at edge N removes the entries, and the next entries appear in the same slots after edge N.
- **Flush.** Asserted at edge N, it gives `count=0` and `fetch_ready=1` after edge N. A fetch group presented in that cycle is lost.
- **Throughput.** Sustained 4 in / 4 out per cycle while `count ≤ DEPTH-4`.
- **Full boundary.**
  - At `count = DEPTH-3 .. DEPTH`, `fetch_ready=0`.
  - At `count = DEPTH-4`, a 4-slot push fills the buffer exactly.
- **Empty boundary.** `decode_pop` with `count=0` is a no-op.

## Test plan
- **Reset/idle.** Hold `rst_n=0`, then release.
  - Required: `count=0`, `fetch_ready=1`, all `decode_out.is_valid=0`.
  - Then `decode_pop=4`: `count` stays 0.
- **Fill and stall.** Push 4 valid slots per cycle (pc `0x1000`, `0x1004`, …) for 4 cycles with `DEPTH=16` and no pops.
  - Required: `count=16`, `fetch_ready=0`.
  - A 5th group presented now is ignored.
  - `decode_out[0].pc=0x1000`, `decode_out[3].pc=0x100C`.
- **Compaction.** Push `fetch_in` with `is_valid=1,0,1,0`, pcs A, B, C, D.
  - Required: `count=2`, `decode_out[0].pc=A`, `decode_out[1].pc=C`, `decode_out[2].is_valid=0`.
- **Simultaneous push/pop with wrap.** From `count=12` with `head=14`, push 4 and pop 3 for 6 cycles.
  - Required: `count` reaches 18? No: `count` rises by 1 per cycle only while `fetch_ready`.
  - Pointer wrap preserves pc order with no gaps or duplicates; checked against a scoreboard.
- **Over-pop.** Set `count=2` and `decode_pop=4`.
  - Required: `count=0` next cycle, and the next push appears at `decode_out[0]`.
- **Flush and reset mid-stream.**
  - With `count=10`, assert `flush` together with a valid push and `decode_pop=2`. Required: `count=0` next cycle and nothing from the push retained.
  - Refill, then drop `rst_n` between edges. Required: `count` and `decode_out.is_valid` go to 0 immediately.

Source files
------------

// File: rtl/inst_buffer_if.sv
// Instruction buffer shared types and bus interface.
//   inst_buffer_pkg : DECODE_REQUIRE slot record (one fetched instruction).
//   inst_buffer_if  : fetch/decode handshake bundle.
//     flush       - synchronous clear of all buffered entries
//     fetch_in    - four fetched slots, index 0 oldest
//     fetch_ready - buffer can absorb a full 4-slot group
//     decode_out  - four oldest entries, index 0 is the head
//     decode_pop  - number of entries decode consumed (0-4, larger clipped)
//     count       - registered occupancy
//   master modport: fetch/decode side; slave modport: the buffer.
package inst_buffer_pkg;
  typedef struct packed {
    logic        is_valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] predict_pc_addr;
    logic        predict_brunch_taken;
  } DECODE_REQUIRE;
endpackage

interface inst_buffer_if #(parameter int CNT_W = 5);
  import inst_buffer_pkg::*;
  logic                  flush;
  DECODE_REQUIRE [3:0]   fetch_in;
  logic                  fetch_ready;
  DECODE_REQUIRE [3:0]   decode_out;
  logic [2:0]            decode_pop;
  logic [CNT_W-1:0]      count;

  modport master (output flush, fetch_in, decode_pop,
                  input  fetch_ready, decode_out, count);
  modport slave  (input  flush, fetch_in, decode_pop,
                  output fetch_ready, decode_out, count);
endinterface

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: a circular FIFO of DEPTH
// entries taking up to four slots per cycle (invalid slots compacted out)
// and retiring up to four per cycle as reported by decode.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - inst_buffer_if.slave (flush, fetch_in, fetch_ready,
//           decode_out, decode_pop, count)
// Full vs empty is tracked by count only; pointers may be equal in both.

// One output lane: masks the stored entry unless it is live.
module inst_buffer_lane
  import inst_buffer_pkg::*;
(
  input  DECODE_REQUIRE entry,
  input  logic          live,
  output DECODE_REQUIRE slot
);
  always_comb begin
    slot = '0;
    if (live) begin
      slot          = entry;
      slot.is_valid = 1'b1;
    end
  end
endmodule

module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  inst_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LANES = 4;

  DECODE_REQUIRE        mem [DEPTH];
  logic [PTR_W-1:0]     head, tail;
  logic [CNT_W-1:0]     cnt;

  logic                 push_en;
  logic [2:0]           vld_cnt, push_n, pop_n;
  logic [LANES-1:0][2:0] offs;
  DECODE_REQUIRE [LANES-1:0] rd_q;

  // Ready uses registered count only; same-cycle pops do not help.
  assign bus.fetch_ready = (cnt <= CNT_W'(DEPTH - LANES));
  assign bus.count       = cnt;
  assign bus.decode_out  = rd_q;
  assign push_en         = bus.fetch_ready && !bus.flush;

  // Compaction: each valid slot lands at tail + (valid slots before it).
  always_comb begin
    vld_cnt = '0;
    offs    = '0;
    for (int i = 0; i < LANES; i++) begin
      offs[i] = vld_cnt;
      if (bus.fetch_in[i].is_valid) vld_cnt = vld_cnt + 3'd1;
    end
    push_n = push_en ? vld_cnt : 3'd0;
  end

  // Clip pop to occupancy; also covers the 5-7 encodings.
  always_comb begin
    pop_n = bus.decode_pop;
    if (CNT_W'(bus.decode_pop) > cnt) pop_n = 3'(cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (bus.flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PTR_W'(pop_n);
      tail <= tail + PTR_W'(push_n);
      cnt  <= cnt + CNT_W'(push_n) - CNT_W'(pop_n);
    end
  end

  // Entry storage needs no reset: visibility is governed by count.
  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < LANES; i++)
        if (bus.fetch_in[i].is_valid)
          mem[tail + PTR_W'(offs[i])] <= bus.fetch_in[i];
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    inst_buffer_lane u_lane (
      .entry (mem[head + PTR_W'(i)]),
      .live  (CNT_W'(i) < cnt),
      .slot  (rd_q[i])
    );
  end
endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer (DEPTH=16). The driver pushes every
// accepted entry onto sb_q; the monitor pops one per consumed output slot
// on the falling edge and compares, alongside count/ready/valid checks.
module tb_inst_buffer;
  import inst_buffer_pkg::*;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_buffer_if #(.CNT_W(5)) bus ();
  inst_buffer #(.DEPTH(DEPTH), .CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  DECODE_REQUIRE sb_q[$];
  int mcount = 0;
  int n_cmp  = 0;
  int n_bad  = 0;
  DECODE_REQUIRE [3:0] zero_g = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic DECODE_REQUIRE mk(input logic [31:0] pc, input logic v);
    DECODE_REQUIRE r;
    r.is_valid             = v;
    r.pc                   = pc;
    r.inst                 = pc ^ 32'hA5A5_0000;
    r.predict_pc_addr      = pc + 32'd8;
    r.predict_brunch_taken = pc[2];
    return r;
  endfunction

  function automatic DECODE_REQUIRE [3:0] grp(input logic [31:0] base, input logic [3:0] mask);
    DECODE_REQUIRE [3:0] g;
    for (int i = 0; i < 4; i++) g[i] = mk(base + 32'(4 * i), mask[i]);
    return g;
  endfunction

  // Drive one cycle starting just after a rising edge; update the model at the edge.
  task automatic step(input DECODE_REQUIRE [3:0] f, input logic [2:0] pop, input logic fl);
    int pn;
    bus.fetch_in   = f;
    bus.decode_pop = pop;
    bus.flush      = fl;
    @(posedge clk);
    if (fl) begin
      sb_q.delete();
      mcount = 0;
    end else begin
      pn = (int'(pop) > mcount) ? mcount : int'(pop);
      if (mcount <= DEPTH - 4) begin
        for (int i = 0; i < 4; i++)
          if (f[i].is_valid) begin
            sb_q.push_back(f[i]);
            mcount++;
          end
      end
      mcount = mcount - pn;
    end
    #1;
    bus.fetch_in   = '0;
    bus.decode_pop = '0;
    bus.flush      = 1'b0;
  endtask

  // Monitor: state checks plus in-order comparison of consumed entries.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("mon_count", 128'(bus.count), 128'(mcount));
      chk("mon_ready", 128'(bus.fetch_ready), 128'(mcount <= DEPTH - 4));
      for (int i = 0; i < 4; i++)
        chk($sformatf("mon_valid%0d", i), 128'(bus.decode_out[i].is_valid), 128'(i < mcount));
      if (!bus.flush) begin
        for (int i = 0; i < 4; i++) begin
          if (i < int'(bus.decode_pop) && bus.decode_out[i].is_valid) begin
            if (sb_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL sb_underflow: got pc %0h expected no entry", bus.decode_out[i].pc);
            end else begin
              chk($sformatf("sb_entry%0d", i), 128'(bus.decode_out[i]), 128'(sb_q.pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.flush      = 1'b0;
    bus.fetch_in   = '0;
    bus.decode_pop = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 128'(bus.count), 128'd0);
    chk("rst_ready", 128'(bus.fetch_ready), 128'd1);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_slot%0d", i), 128'(bus.decode_out[i]), 128'd0);
    rst_n = 1'b1;

    step(zero_g, 3'd4, 1'b0);
    chk("idle_pop_count", 128'(bus.count), 128'd0);

    // Fill and stall
    for (int g = 0; g < 4; g++) step(grp(32'h1000 + 32'(16 * g), 4'hF), 3'd0, 1'b0);
    chk("fill_count", 128'(bus.count), 128'd16);
    chk("fill_ready", 128'(bus.fetch_ready), 128'd0);
    chk("fill_pc0", 128'(bus.decode_out[0].pc), 128'h1000);
    chk("fill_pc3", 128'(bus.decode_out[3].pc), 128'h100C);
    step(grp(32'h2000, 4'hF), 3'd0, 1'b0);
    chk("ignored_count", 128'(bus.count), 128'd16);
    chk("ignored_pc0", 128'(bus.decode_out[0].pc), 128'h1000);

    // Move head to 14, refill to 12, then push 4 / pop 3 across the wrap
    repeat (3) step(zero_g, 3'd4, 1'b0);
    step(zero_g, 3'd2, 1'b0);
    chk("head14_count", 128'(bus.count), 128'd2);
    step(grp(32'h3000, 4'hF), 3'd0, 1'b0);
    step(grp(32'h3010, 4'hF), 3'd0, 1'b0);
    step(grp(32'h3020, 4'b0011), 3'd0, 1'b0);
    chk("wrap_start_count", 128'(bus.count), 128'd12);
    for (int k = 0; k < 6; k++) step(grp(32'h4000 + 32'(16 * k), 4'hF), 3'd3, 1'b0);
    chk("wrap_end_count", 128'(bus.count), 128'd10);
    for (int n = 0; n < 10 && mcount > 0; n++) step(zero_g, 3'd4, 1'b0);
    chk("drain_count", 128'(bus.count), 128'd0);

    // Compaction
    step(grp(32'h5000, 4'b0101), 3'd0, 1'b0);
    chk("comp_count", 128'(bus.count), 128'd2);
    chk("comp_pc0", 128'(bus.decode_out[0].pc), 128'h5000);
    chk("comp_pc1", 128'(bus.decode_out[1].pc), 128'h5008);
    chk("comp_valid2", 128'(bus.decode_out[2].is_valid), 128'd0);

    // Over-pop
    step(zero_g, 3'd4, 1'b0);
    chk("overpop_count", 128'(bus.count), 128'd0);
    step(grp(32'h6000, 4'hF), 3'd0, 1'b0);
    chk("overpop_next_pc0", 128'(bus.decode_out[0].pc), 128'h6000);

    // Flush with simultaneous push and pop
    step(grp(32'h6010, 4'hF), 3'd0, 1'b0);
    step(grp(32'h6020, 4'b0011), 3'd0, 1'b0);
    chk("preflush_count", 128'(bus.count), 128'd10);
    step(grp(32'h7000, 4'hF), 3'd2, 1'b1);
    chk("flush_count", 128'(bus.count), 128'd0);
    chk("flush_ready", 128'(bus.fetch_ready), 128'd1);
    chk("flush_valid0", 128'(bus.decode_out[0].is_valid), 128'd0);
    step(zero_g, 3'd0, 1'b0);
    chk("flush_nothing_kept", 128'(bus.count), 128'd0);

    // Refill, then async reset between edges
    step(grp(32'h8000, 4'hF), 3'd0, 1'b0);
    step(grp(32'h8010, 4'hF), 3'd0, 1'b0);
    chk("refill_count", 128'(bus.count), 128'd8);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    mcount = 0;
    #1;
    chk("async_rst_count", 128'(bus.count), 128'd0);
    chk("async_rst_ready", 128'(bus.fetch_ready), 128'd1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("async_rst_valid%0d", i), 128'(bus.decode_out[i].is_valid), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Pop encoding 7 clips to occupancy
    step(grp(32'h9000, 4'hF), 3'd0, 1'b0);
    step(zero_g, 3'd7, 1'b0);
    chk("pop7_count", 128'(bus.count), 128'd0);
    chk("sb_empty", 128'(sb_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
